div_unit: RTL and testbench

//   Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU group.
//   The combinational ALU does not cover division.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 21 ++
 rtl/div_unit.sv | 135 +++++++++++++
 tb/tb_div_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider: operation codes and FSM states.
package div_pkg;

  typedef enum logic [1:0] {
    DIVOP_DIV  = 2'b00,
    DIVOP_DIVU = 2'b01,
    DIVOP_REM  = 2'b10,
    DIVOP_REMU = 2'b11
  } divop_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] dsr,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0]   trial;
  logic [XLEN+1:0] diff;

  // Extra guard bit keeps the borrow even if the partial remainder ever reaches dsr.
  assign trial    = {rem, dvd_msb};
  assign diff     = {1'b0, trial} - {2'b00, dsr};
  assign q_bit    = ~diff[XLEN+1];
  assign rem_next = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      DivOp,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Res
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_reg;
  divop_e            op_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [XLEN-1:0]   rem_reg;
  logic [XLEN-1:0]   dvd_reg;
  logic [XLEN-1:0]   dsr_reg;
  logic              q_neg_reg;
  logic              r_neg_reg;
  logic [XLEN-1:0]   res_reg;
  logic              done_reg;
  logic              busy_reg;

  logic              signed_op;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic              b_zero;
  logic              ovf;
  logic [XLEN-1:0]   step_rem;
  logic              step_q;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;

  // DIV and REM have a zero in bit 0 of their encoding.
  assign signed_op = ~DivOp[0];
  assign a_abs     = (signed_op && A[XLEN-1]) ? (~A + 1'b1) : A;
  assign b_abs     = (signed_op && B[XLEN-1]) ? (~B + 1'b1) : B;
  assign b_zero    = (B == '0);
  assign ovf       = signed_op && (A == MIN_NEG) && (B == '1);

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_reg),
    .dvd_msb  (dvd_reg[XLEN-1]),
    .dsr      (dsr_reg),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // The dividend register doubles as the quotient: q bits enter as dividend bits leave.
  assign q_fix = q_neg_reg ? (~dvd_reg + 1'b1) : dvd_reg;
  assign r_fix = r_neg_reg ? (~rem_reg + 1'b1) : rem_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      op_reg    <= DIVOP_DIV;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      dvd_reg   <= '0;
      dsr_reg   <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      res_reg   <= '0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg   <= divop_e'(DivOp);
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
            dsr_reg  <= b_abs;
            if (b_zero) begin
              dvd_reg   <= '1;
              rem_reg   <= A;
              q_neg_reg <= 1'b0;
              r_neg_reg <= 1'b0;
              state_reg <= S_FIX;
            end else if (ovf) begin
              dvd_reg   <= MIN_NEG;
              rem_reg   <= '0;
              q_neg_reg <= 1'b0;
              r_neg_reg <= 1'b0;
              state_reg <= S_FIX;
            end else begin
              dvd_reg   <= a_abs;
              rem_reg   <= '0;
              q_neg_reg <= signed_op & (A[XLEN-1] ^ B[XLEN-1]);
              r_neg_reg <= signed_op & A[XLEN-1];
              state_reg <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_reg <= step_rem;
          dvd_reg <= {dvd_reg[XLEN-2:0], step_q};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(XLEN-1)) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          res_reg   <= op_reg[1] ? r_fix : q_fix;
          done_reg  <= 1'b1;
          state_reg <= S_DONE;
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign Res  = res_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: results, latency, ignored start and reset abort.
module tb_div_unit;
  import div_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  DivOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Res;

  int vectors;
  int miscompares;

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .DivOp (DivOp),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Res   (Res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request before the next rising edge, drop it just after that edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    DivOp = op;
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = 32'hDEAD_BEEF;
    B     = 32'h0BAD_F00D;
    DivOp = 2'b11;
  endtask

  // Latency counts the accepting edge as edge 1; bounded so a stuck DUT cannot hang.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int bc;
    issue(op, a, b);
    wait_done(lat, bc);
    $display("op=%0d A=%h B=%h Res=%h latency=%0d", op, a, b, Res, lat);
    check({tag, "_res"}, Res, exp_res);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int bc;
    int nd;
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    DivOp = 2'b00;
    A     = '0;
    B     = '0;

    // Reset state
    #22;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_res", Res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Basic DIV/REM with latency and busy width
    issue(DIVOP_DIV, 32'd100, 32'd7);
    wait_done(lat, bc);
    $display("op=DIV A=100 B=7 Res=%h latency=%0d busy_cycles=%0d", Res, lat, bc);
    check("div_100_7", Res, 32'd14);
    check("div_latency", 32'(lat), 32'd34);
    check("div_busy_cycles", 32'(bc), 32'd34);
    run("rem_100_7", DIVOP_REM, 32'd100, 32'd7, 32'd2, 34);

    // 2. Signed truncation toward zero
    run("div_m7_2", DIVOP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run("rem_m7_2", DIVOP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run("rem_7_m2", DIVOP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    run("divu_big", DIVOP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);

    // 3. Divide by zero
    run("divu_5_0", DIVOP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run("remu_5_0", DIVOP_REMU, 32'd5, 32'd0, 32'd5, 2);
    run("div_m5_0", DIVOP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 2);

    // 4. Signed overflow
    run("div_ovf", DIVOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run("rem_ovf", DIVOP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

    // 5. Start pulsed mid-calculation must be ignored
    issue(DIVOP_DIV, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    DivOp = DIVOP_DIVU;
    A     = 32'd1000;
    B     = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    $display("op=DIV A=100 B=7 (start pulsed while busy) Res=%h", Res);
    check("ignored_start_res", Res, 32'd14);
    count_dones(40, nd);
    check("ignored_start_extra_done", 32'(nd), 32'd0);
    check("ignored_start_idle", {31'b0, busy}, 32'd0);
    run("retry_divu", DIVOP_DIVU, 32'd1000, 32'd3, 32'd333, 34);

    // 6. Reset during calculation aborts without done
    issue(DIVOP_DIVU, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    $display("reset asserted mid-CALC busy=%b done=%b Res=%h", busy, done, Res);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_res", Res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(40, nd);
    check("abort_no_done", 32'(nd), 32'd0);
    run("post_reset_divu", DIVOP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
